// File: rtl/redirect_route_ctrl_pkg.sv
// Shared types for the redirect routing controller: per-port FSM states and the route record.
package ariane_soc;

    localparam int unsigned INIT_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN_ON  = 2'd1,
        ACTIVE    = 2'd2,
        DRAIN_OFF = 2'd3
    } redirect_state_t;

    typedef struct packed {
        logic                  en;
        logic [INIT_IDX_W-1:0] src;
        logic [INIT_IDX_W-1:0] tgt;
    } route_t;

    function automatic logic is_drain(input redirect_state_t s);
        return (s == DRAIN_ON) || (s == DRAIN_OFF);
    endfunction

endpackage

// File: rtl/redirect_route_ctrl_port.sv
// Single-port redirect FSM with outstanding-burst counter; override visible 2 cycles after request.
// Gate asserts while draining or when the counter saturates; watchdog under REDIRECT_DRAIN_TIMEOUT_EN.
module redirect_route_port
    import ariane_soc::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TMO_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [INIT_IDX_W-1:0] source_i,
    input  logic [INIT_IDX_W-1:0] target_i,
    input  logic                  req_fire_i,
    input  logic                  rsp_done_i,
    output logic                  gate_req_o,
    output route_t                route_o,
    output logic                  drain_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    redirect_state_t       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [INIT_IDX_W-1:0] src_q, tgt_q;
    logic                  latch;
    logic                  gate_q;
    logic                  tmo_hit;
    logic                  route_on;

    always_comb begin
        cnt_d = cnt_q;
        if (tmo_hit) begin
            cnt_d = '0;
        end else if (req_fire_i && !rsp_done_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rsp_done_i && !req_fire_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Drain completion looks at the post-update count so the switch happens the cycle after it empties.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid_i) begin
                    state_d = DRAIN_ON;
                    latch   = 1'b1;
                end
            end
            DRAIN_ON: begin
                if (!redirect_valid_i) begin
                    state_d = IDLE;
                end else if (cnt_d == '0) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!redirect_valid_i) begin
                    state_d = DRAIN_OFF;
                end else if ((source_i != src_q) || (target_i != tgt_q)) begin
                    state_d = DRAIN_ON;
                    latch   = 1'b1;
                end
            end
            DRAIN_OFF: begin
                if (redirect_valid_i) begin
                    state_d = DRAIN_ON;
                    latch   = 1'b1;
                end else if (cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d = IDLE;
            latch   = 1'b0;
        end
    end

    // The gate covers both the current and the next state, so it releases one cycle after the route flips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            tgt_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= is_drain(state_q) || is_drain(state_d);
            if (latch) begin
                src_q <= source_i;
                tgt_q <= target_i;
            end
        end
    end

    assign route_on   = (state_q == ACTIVE) || (state_q == DRAIN_OFF);
    assign route_o    = route_on ? '{en: 1'b1, src: src_q, tgt: tgt_q} : '0;
    assign gate_req_o = gate_q || (cnt_q == CNT_MAX);

`ifdef REDIRECT_DRAIN_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = is_drain(state_q) && (tmo_q == {TMO_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_d != state_q) || !is_drain(state_q)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign drain_err_o = err_q;
`else
    // No watchdog: a drain waits for its last response indefinitely.
    assign tmo_hit     = 1'b0;
    assign drain_err_o = |{TMO_W{1'b0}};
`endif

endmodule

// File: rtl/redirect_route_ctrl.sv
// Crossbar redirect override controller: one independent drain-safe FSM per target port.
// Override follows request by 2 cycles on an idle port; optional watchdog via REDIRECT_DRAIN_TIMEOUT_EN.
module redirect_route_ctrl
    import ariane_soc::*;
#(
    parameter int unsigned N_TARG_PORT = 7,
    parameter int unsigned LOG_N_INIT  = INIT_IDX_W,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned TMO_W       = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_TARG_PORT-1:0]                redirect_valid_i,
    input  logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] source_i,
    input  logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] target_i,
    input  logic [N_TARG_PORT-1:0]                req_fire_i,
    input  logic [N_TARG_PORT-1:0]                rsp_done_i,
    output logic [N_TARG_PORT-1:0]                gate_req_o,
    output logic [N_TARG_PORT-1:0]                route_en_o,
    output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] route_src_o,
    output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] route_tgt_o,
    output logic [N_TARG_PORT-1:0]                drain_err_o
);

    for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_port
        route_t route;

        redirect_route_port #(
            .CNT_W (CNT_W),
            .TMO_W (TMO_W)
        ) u_port (
            .clk              (clk),
            .rst              (rst),
            .redirect_valid_i (redirect_valid_i[p]),
            .source_i         (source_i[p]),
            .target_i         (target_i[p]),
            .req_fire_i       (req_fire_i[p]),
            .rsp_done_i       (rsp_done_i[p]),
            .gate_req_o       (gate_req_o[p]),
            .route_o          (route),
            .drain_err_o      (drain_err_o[p])
        );

        assign route_en_o[p]  = route.en;
        assign route_src_o[p] = route.src;
        assign route_tgt_o[p] = route.tgt;
    end

endmodule

// File: tb/tb_redirect_route_ctrl.sv
// Bench for redirect_route_ctrl: per-cycle vector table on port 0 plus hand sequences for saturation and reset.
module tb_redirect_route_ctrl;

    localparam int unsigned NP = 7;
    localparam int unsigned LW = 2;
    localparam int unsigned CW = 4;
`ifdef REDIRECT_DRAIN_TIMEOUT_EN
    localparam int unsigned TW = 4;
`else
    localparam int unsigned TW = 10;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          redirect_valid_i, req_fire_i, rsp_done_i;
    logic [NP-1:0][LW-1:0]  source_i, target_i;
    logic [NP-1:0]          gate_req_o, route_en_o, drain_err_o;
    logic [NP-1:0][LW-1:0]  route_src_o, route_tgt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    redirect_route_ctrl #(
        .N_TARG_PORT (NP),
        .LOG_N_INIT  (LW),
        .CNT_W       (CW),
        .TMO_W       (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .source_i         (source_i),
        .target_i         (target_i),
        .req_fire_i       (req_fire_i),
        .rsp_done_i       (rsp_done_i),
        .gate_req_o       (gate_req_o),
        .route_en_o       (route_en_o),
        .route_src_o      (route_src_o),
        .route_tgt_o      (route_tgt_o),
        .drain_err_o      (drain_err_o)
    );

    // Expected word per port: {err, gate, en, src[1:0], tgt[1:0]}
    typedef struct {
        logic       vld;
        logic [1:0] src;
        logic [1:0] tgt;
        logic       fire;
        logic       done;
        logic [6:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] sb[$];

    function automatic vec_t mk(input int v, input int s, input int t, input int f, input int d,
                                input int g, input int e, input int es, input int et);
        vec_t r;
        r.vld  = 1'(v);
        r.src  = 2'(s);
        r.tgt  = 2'(t);
        r.fire = 1'(f);
        r.done = 1'(d);
        r.exp  = {1'b0, 1'(g), 1'(e), 2'(es), 2'(et)};
        return r;
    endfunction

    function automatic logic [6:0] obs(input int p);
        return {drain_err_o[p], gate_req_o[p], route_en_o[p], route_src_o[p], route_tgt_o[p]};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (err,gate,en,src,tgt)", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [6:0] e;
        int         n;

        rst              = 1'b1;
        redirect_valid_i = '0;
        req_fire_i       = '0;
        rsp_done_i       = '0;
        source_i         = '0;
        target_i         = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("reset_p%0d", p), obs(p), 7'd0);
        rst = 1'b0;

        // vld src tgt fire done | gate en src tgt (after the next edge)
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0,  1, 1, 1, 3));
        tbl.push_back(mk(1, 1, 3, 0, 0,  0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 3, 1, 0,  0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 3, 1, 0,  0, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 1,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 1,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 1,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 1,  1, 1, 2, 1));
        tbl.push_back(mk(1, 2, 1, 0, 0,  0, 1, 2, 1));
        tbl.push_back(mk(1, 2, 2, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 0, 0,  1, 1, 2, 2));
        tbl.push_back(mk(1, 2, 2, 0, 0,  0, 1, 2, 2));
        tbl.push_back(mk(1, 2, 2, 1, 0,  0, 1, 2, 2));
        tbl.push_back(mk(1, 2, 3, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 3, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 3, 0, 1,  1, 1, 2, 3));
        tbl.push_back(mk(1, 2, 3, 0, 0,  0, 1, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 2, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            redirect_valid_i[0] = tbl[i].vld;
            source_i[0]         = tbl[i].src;
            target_i[0]         = tbl[i].tgt;
            req_fire_i[0]       = tbl[i].fire;
            rsp_done_i[0]       = tbl[i].done;
            sb.push_back(tbl[i].exp);
            step();
            e = sb.pop_front();
            check($sformatf("vec%0d", i), obs(0), e);
        end
        redirect_valid_i[0] = 1'b0;
        req_fire_i[0]       = 1'b0;
        rsp_done_i[0]       = 1'b0;

        // Saturation on port 5: the 16th fire must be dropped, the extra response ignored.
        req_fire_i[5] = 1'b1;
        repeat (16) step();
        req_fire_i[5] = 1'b0;
        check("sat_gate", obs(5), 7'b0100000);
        check("sat_neighbour", obs(4), 7'd0);
        rsp_done_i[5] = 1'b1;
        repeat (16) step();
        rsp_done_i[5] = 1'b0;
        check("sat_drained", obs(5), 7'd0);
        redirect_valid_i[5] = 1'b1;
        source_i[5]         = 2'd3;
        target_i[5]         = 2'd0;
        step();
        check("sat_enable_c1", obs(5), 7'b0100000);
        step();
        check("sat_enable_c2", obs(5), {3'b011, 2'd3, 2'd0});
        redirect_valid_i[5] = 1'b0;
        repeat (4) step();
        check("sat_release", obs(5), 7'd0);

        // Asynchronous reset in DRAIN_ON on port 1.
        req_fire_i[1] = 1'b1;
        step();
        req_fire_i[1]       = 1'b0;
        redirect_valid_i[1] = 1'b1;
        source_i[1]         = 2'd1;
        target_i[1]         = 2'd2;
        step();
        check("rst_pre_drain", obs(1), 7'b0100000);
        step();
        check("rst_pre_hold", obs(1), 7'b0100000);
        #2;
        rst = 1'b1;
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("rst_async_p%0d", p), obs(p), 7'd0);
        redirect_valid_i[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("rst_after_idle", obs(1), 7'd0);
        redirect_valid_i[1] = 1'b1;
        step();
        check("rst_reenable_c1", obs(1), 7'b0100000);
        step();
        check("rst_reenable_c2", obs(1), {3'b011, 2'd1, 2'd2});
        redirect_valid_i[1] = 1'b0;
        repeat (4) step();

`ifdef REDIRECT_DRAIN_TIMEOUT_EN
        // Port 3 drains a burst whose response never arrives.
        req_fire_i[3] = 1'b1;
        step();
        req_fire_i[3]       = 1'b0;
        redirect_valid_i[3] = 1'b1;
        source_i[3]         = 2'd0;
        target_i[3]         = 2'd1;
        n = 0;
        while (drain_err_o[3] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check("tmo_latency_ok", 7'(n >= 15 && n <= 18), 7'd1);
        check("tmo_err_state", obs(3), 7'b1100000);
        redirect_valid_i[3] = 1'b0;
        step();
        check("tmo_idle", obs(3), 7'b1000000);
        redirect_valid_i[3] = 1'b1;
        step();
        step();
        check("tmo_cnt_cleared", obs(3), {3'b111, 2'd0, 2'd1});
        redirect_valid_i[3] = 1'b0;
        repeat (3) step();
`else
        n = 0;
        check("no_err_any", 7'(drain_err_o), 7'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redirect_route_ctrl.md
Name: redirect_route_ctrl

Overview:
- Per-target-port controller directly downstream of the redirect-command decoder.
- Consumes each port's decoded redirect_valid/source/target and turns them into routing overrides for the crossbar.
- Switches routing only when the port has no outstanding bursts: new requests are gated while the port drains.
- Gives the crossbar a glitch-free, transaction-safe redirect on/off.

Parameters:
N_TARG_PORT, 7, number of target ports (one independent controller each)
LOG_N_INIT, 2, width of source/target initiator index
CNT_W, 4, width of per-port outstanding-burst counter
TMO_W, 10, width of drain-timeout counter (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
redirect_valid_i  in  N_TARG_PORT  level request from decoder: redirect wanted
source_i  in  N_TARG_PORT x LOG_N_INIT  initiator to redirect from
target_i  in  N_TARG_PORT x LOG_N_INIT  initiator to redirect to
req_fire_i  in  N_TARG_PORT  address handshake completed (valid&ready) this cycle
rsp_done_i  in  N_TARG_PORT  last response beat handshake completed this cycle
gate_req_o  out  N_TARG_PORT  1 = crossbar must hold off new address requests on port
route_en_o  out  N_TARG_PORT  1 = redirect override active
route_src_o  out  N_TARG_PORT x LOG_N_INIT  latched source of active override
route_tgt_o  out  N_TARG_PORT x LOG_N_INIT  latched target of active override
drain_err_o  out  N_TARG_PORT  sticky drain-timeout flag (constant 0 without feature)

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all outputs are 0, all FSMs are IDLE and all counters are 0.
- Outstanding counter per port (cnt):
  - +1 on req_fire_i; -1 on rsp_done_i.
  - Both in the same cycle: unchanged.
  - Saturates at 2^CNT_W-1; an increment at max is dropped.
  - A decrement at 0 is ignored (no underflow).
- gate_req_o is also forced to 1 whenever cnt == max.
- FSM per port, registered:
  - IDLE:
    - route_en_o=0.
    - When redirect_valid_i=1, latch source_i/target_i into shadow registers, go DRAIN_ON, set gate_req_o=1 in the next cycle.
  - DRAIN_ON:
    - gate_req_o=1.
    - If redirect_valid_i drops, return to IDLE (gate released the next cycle).
    - Else when cnt==0 (evaluated after this cycle's update), go ACTIVE.
  - ACTIVE:
    - route_en_o=1 and gate_req_o=0.
    - route_src_o/route_tgt_o are driven from the shadow registers.
    - When redirect_valid_i=0, go DRAIN_OFF.
    - If source_i/target_i change while redirect_valid_i stays 1, go DRAIN_ON and relatch the new values; route_en_o=0 during the drain.
  - DRAIN_OFF:
    - gate_req_o=1 and route_en_o stays 1, so in-flight bursts complete on the redirected path.
    - When cnt==0, go IDLE.
    - If redirect_valid_i reasserts, go DRAIN_ON and relatch.
- Timing: the override is visible 2 cycles after redirect_valid_i rises on an idle port with cnt==0. The gate releases 1 cycle later than route_en_o changes.
- A req_fire_i seen while gated (crossbar race in the same cycle) is still counted.
- Mid-operation reset clears everything immediately; the counters do not attempt to track bursts that were in flight.
- Ports are fully independent: no shared state and no arbitration.

Optional Feature:
- Macro: REDIRECT_DRAIN_TIMEOUT_EN.
- Defined:
  - Per-port TMO_W counter runs in DRAIN_ON/DRAIN_OFF and clears on any state change.
  - On reaching all-ones, set sticky drain_err_o and force the transition: DRAIN_ON->IDLE or DRAIN_OFF->IDLE. Counter cnt is cleared to 0.
  - drain_err_o clears only on reset.
- Undefined: no timeout counter; drain_err_o tied to 0; drains wait indefinitely.

Decomposition:
- Shared package ariane_soc holds:
  - the FSM state enum redirect_state_t (IDLE, DRAIN_ON, ACTIVE, DRAIN_OFF);
  - the route record typedef (en, src, tgt).
- One sub-module, redirect_route_port: a single-port FSM plus counter (plus timeout), instantiated N_TARG_PORT times by a generate loop in the top.

Test Plan:
- Idle enable: port 0, cnt=0; redirect_valid_i[0]=1, src=1, tgt=3 at cycle 0 -> gate_req_o[0]=1 at cycle 1; route_en_o[0]=1 with src=1/tgt=3 at cycle 2; gate_req_o[0]=0 at cycle 3.
- Drain before switch: 3 req_fire_i on port 2, then raise redirect_valid_i -> route_en_o stays 0 until the third rsp_done_i; ACTIVE the cycle after cnt reaches 0.
- Simultaneous events and saturation:
  - req_fire_i and rsp_done_i together at cnt=2 -> cnt stays 2.
  - 16 fires with CNT_W=4 -> cnt=15; gate_req_o=1 with no redirect.
- Disable with traffic: ACTIVE, 2 outstanding, drop redirect_valid_i -> route_en_o stays 1 until both responses complete, then 0 and IDLE; gate_req_o=1 throughout the drain.
- Retarget and reset:
  - In ACTIVE, change tgt 3->2 with valid held -> route_en_o goes 0, drains, then re-enables with tgt=2.
  - rst pulsed during DRAIN_ON -> all outputs 0 immediately, without waiting for a clock edge.
- Timeout (REDIRECT_DRAIN_TIMEOUT_EN, TMO_W=4): enter DRAIN_ON with 1 outstanding and no response -> after 15 cycles drain_err_o=1, FSM IDLE, cnt=0.
